button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//  Front-end conditioning for the pushbutton inputs of the basic logic-gate designs.
//  Synchronises N raw, bouncing button inputs into the clock domain.
//  Debounces each one and drives clean levels straight into gate inputs (x0, x1, ...).
//  Sits directly upstream of the combinational gate modules, between board pins and gate.
// PARAMETERS
//  N        2       number of independent button channels
//  CNT_MAX  240000  stable cycles required to accept a change (20 ms @ 12 MHz); must be >= 1
// PORTS
//  clk     input   1  system clock (12 MHz board oscillator)
//  rst     input   1  reset: synchronous, active-high
//  x_raw   input   N  raw asynchronous button levels from pins
//  x_db    output  N  debounced levels, feed gate inputs
//  x_rise  output  N  one-cycle pulse on accepted 0->1 (only with DEBOUNCE_PULSE_EN)
//  x_fall  output  N  one-cycle pulse on accepted 1->0 (only with DEBOUNCE_PULSE_EN)
// BEHAVIOUR
//  - One clock domain: clk. Reset is synchronous and active-high: rst sampled on the rising clk edge only.
//  - Reset: sync FFs, counters, x_db, x_rise, x_fall all 0. rst asserted mid-count aborts the count.
//    After reset, a held-high input must re-qualify for the full CNT_MAX.
//  - Per channel i, channels fully independent:
//    - 2-FF synchroniser: s1 <= x_raw[i]; s2 <= s1.
//    - CW = $clog2(CNT_MAX+1) bit counter cnt.
//    - If s2 == x_db[i]: cnt <= 0.
//    - If s2 != x_db[i] and cnt == CNT_MAX-1: x_db[i] <= s2 and cnt <= 0.
//    - Else: cnt <= cnt + 1.
//  - Latency: a clean step on x_raw appears on x_db exactly CNT_MAX+2 rising edges later,
//    counting the edge that first samples it into s1.
//  - Glitch or bounce: any return of s2 to x_db before the count completes clears cnt and leaves x_db unchanged.
//    A pulse held for CNT_MAX-1 cycles or fewer in s2 is rejected.
//  - Counter never exceeds CNT_MAX-1, so there is no wrap-around.
//  - Simultaneous changes on several channels each complete on their own schedule.
//  - x_db is registered, glitch-free, and safe to drive combinational gates directly.
// CONFIGURATION
//  DEBOUNCE_PULSE_EN defined:
//    - x_rise/x_fall ports exist and are registered.
//    - x_rise[i] is 1 for exactly the one cycle in which x_db[i] becomes 1; x_fall likewise on 1->0.
//    - Both pulses are 0 in reset.
//  DEBOUNCE_PULSE_EN undefined:
//    - x_rise/x_fall ports and their logic are absent.
//    - x_db behaviour is identical in both builds.
// STRUCTURE
//  Shared package/header (board_defs): board clock frequency 12_000_000 and default debounce time 20 ms.
//  CNT_MAX default is derived from these.
//  Sub-module debounce_channel:
//    - One channel: synchroniser, counter, level register (plus pulse regs under the macro).
//    - Instantiated N times in a generate loop.
//    - Top level is only the generate wrapper.
// TESTING  (CNT_MAX=4, N=2 for simulation)
//  - Reset: hold rst 3 cycles with x_raw=2'b11 -> x_db=0 throughout reset.
//    After release, x_db=2'b11 exactly 6 edges after the first non-reset sampling edge.
//  - Clean press: x_raw[0] 0->1 and held -> x_db[0] rises after exactly 6 edges.
//    With DEBOUNCE_PULSE_EN, x_rise[0]=1 for 1 cycle in that same cycle; x_db[1] stays 0.
//  - Bounce: x_raw[0] toggles 1,0,1,0 at 2-cycle spacing, then holds 1
//    -> x_db[0] rises once, 6 edges after the final 0->1 edge; no intermediate change.
//  - Glitch reject: x_raw[1]=1 for 3 cycles, then back to 0 -> x_db[1] remains 0; x_rise[1] never pulses.
//  - Reset mid-count: x_raw[0]=1 held; assert rst for 1 cycle after 3 counting cycles
//    -> x_db[0] stays 0 and rises only 6 edges after the first post-reset sampling edge.
//  - Independence: x_raw[0] rises at cycle 0, x_raw[1] rises at cycle 2 -> x_db[0] rises at edge 6, x_db[1] at edge 8.
//    Releases then produce x_fall pulses with the same spacing.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Board-level defaults shared by the button front-end: oscillator
// frequency, nominal debounce time, and the counter width helper.
package button_debounce_pkg;

  localparam int BOARD_CLK_HZ    = 12_000_000;
  localparam int DEBOUNCE_MS     = 20;
  localparam int DEFAULT_CNT_MAX = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;

  // Bits needed to hold 0..cnt_max.
  function automatic int cnt_width(input int cnt_max);
    return $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, stability counter, registered
// debounced level. With DEBOUNCE_PULSE_EN defined it also registers
// one-cycle rise/fall pulses aligned with the level change.
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
`ifdef DEBOUNCE_PULSE_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int             CW   = cnt_width(CNT_MAX);
  localparam logic [CW-1:0]  LAST = CW'(CNT_MAX - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // Synchronised level has differed from db for CNT_MAX consecutive cycles.
  assign accept = (s2 != db) && (cnt == LAST);

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (accept) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef DEBOUNCE_PULSE_EN
  // Edge pulses land in the same cycle db takes its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept &  s2;
      fall <= accept & ~s2;
    end
  end
`endif

endmodule

// File: rtl/button_debounce.sv
// N independent debounced button channels; thin generate wrapper around
// debounce_channel. Optional edge pulse outputs under DEBOUNCE_PULSE_EN.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int N       = 2,
  parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] x_raw,
  output logic [N-1:0] x_db
`ifdef DEBOUNCE_PULSE_EN
  ,
  output logic [N-1:0] x_rise,
  output logic [N-1:0] x_fall
`endif
);

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .CNT_MAX (CNT_MAX)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (x_raw[i]),
      .db   (x_db[i])
`ifdef DEBOUNCE_PULSE_EN
      ,
      .rise (x_rise[i]),
      .fall (x_fall[i])
`endif
    );
  end

endmodule
